// File: rtl/bram_weight_loader_if.sv
// Word stream into the weight BRAM fill stage: valid/ready with an end-of-transfer marker.
interface bram_weight_loader_if #(
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_DATA_WIDTH-1:0] s_data;
  logic                      s_valid;
  logic                      s_last;
  logic                      s_ready;

  // Word producer side
  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  // Loader side
  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/bram_weight_loader.sv
// Packs a 32-bit word stream into 5*MAC_NUM-bit lines and writes them to
// consecutive weight BRAM addresses, then flags the load as complete.
module bram_weight_loader #(
  parameter int MAC_NUM            = 256,
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int AXI_DATA_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [BRAM_ADDRESS_WIDTH-1:0]   base_addr,
  input  logic [BRAM_ADDRESS_WIDTH:0]     num_lines,
  bram_weight_loader_if.slave             s_if,
  output logic                            bram_en,
  output logic                            bram_we,
  output logic [BRAM_ADDRESS_WIDTH-1:0]   bram_addr,
  output logic [5*MAC_NUM-1:0]            bram_wdata,
  output logic                            busy,
  output logic                            done,
  output logic                            weights_ready,
  output logic                            error
);

  localparam int LINE_W         = 5 * MAC_NUM;
  localparam int WORDS_PER_LINE = LINE_W / AXI_DATA_WIDTH;
  localparam int WCW            = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LCW            = BRAM_ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e                          state_q, state_d;
  logic [BRAM_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [LCW-1:0]                  lines_q, lines_d;
  logic [WCW-1:0]                  word_q, word_d;
  logic [LINE_W-1:0]               buf_q, buf_d;
  logic                            error_q, error_d;
  logic                            ready_q, ready_d;

  logic hs;
  logic last_word;
  logic final_word;

  // Handshake and line/transfer position decode
  always_comb begin
    hs         = s_if.s_valid && (state_q == FILL);
    last_word  = (word_q == WCW'(WORDS_PER_LINE - 1));
    final_word = last_word && (lines_q == LCW'(1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: address/line/word counters, line buffer, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      lines_q <= '0;
      word_q  <= '0;
      buf_q   <= '0;
      error_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      lines_q <= lines_d;
      word_q  <= word_d;
      buf_q   <= buf_d;
      error_q <= error_d;
      ready_q <= ready_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (num_lines == '0) ? DONE : FILL;
      FILL:  if (hs) begin
               if (s_if.s_last && !final_word) state_d = IDLE;
               else if (last_word)             state_d = WRITE;
             end
      WRITE: state_d = (lines_q == LCW'(1)) ? DONE : FILL;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates; weights_ready is raised alongside the move into DONE so it
  // coincides with the done pulse
  always_comb begin
    addr_d  = addr_q;
    lines_d = lines_q;
    word_d  = word_q;
    buf_d   = buf_q;
    error_d = error_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = base_addr;
        lines_d = num_lines;
        word_d  = '0;
        error_d = 1'b0;
        ready_d = (num_lines == '0);
      end
      FILL: if (hs) begin
        buf_d[int'(word_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = s_if.s_data;
        if (s_if.s_last && !final_word) begin
          error_d = 1'b1;
          word_d  = '0;
        end else if (last_word) begin
          word_d = '0;
        end else begin
          word_d = word_q + WCW'(1);
        end
      end
      WRITE: begin
        addr_d  = addr_q + BRAM_ADDRESS_WIDTH'(1);
        lines_d = lines_q - LCW'(1);
        if (lines_q == LCW'(1)) ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state and registered datapath
  always_comb begin
    s_if.s_ready  = (state_q == FILL);
    busy          = (state_q == FILL) || (state_q == WRITE);
    bram_en       = (state_q == WRITE);
    bram_we       = (state_q == WRITE);
    done          = (state_q == DONE);
    bram_addr     = addr_q;
    bram_wdata    = buf_q;
    weights_ready = ready_q;
    error         = error_q;
  end

endmodule

// File: tb/tb_bram_weight_loader.sv
// Directed-sequence bench with random data/valid gaps, checked against a
// line-packing reference built from the word list.
module tb_bram_weight_loader;

  localparam int MAC_NUM = 256;
  localparam int BAW     = 12;
  localparam int AXW     = 32;
  localparam int LINE_W  = 5 * MAC_NUM;
  localparam int WPL     = LINE_W / AXW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [BAW-1:0]    base_addr = '0;
  logic [BAW:0]      num_lines = '0;
  logic              bram_en, bram_we;
  logic [BAW-1:0]    bram_addr;
  logic [LINE_W-1:0] bram_wdata;
  logic              busy, done, weights_ready, error;

  bram_weight_loader_if #(.AXI_DATA_WIDTH(AXW)) s_if ();

  bram_weight_loader #(
    .MAC_NUM            (MAC_NUM),
    .BRAM_ADDRESS_WIDTH (BAW),
    .AXI_DATA_WIDTH     (AXW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .num_lines     (num_lines),
    .s_if          (s_if.slave),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_wdata    (bram_wdata),
    .busy          (busy),
    .done          (done),
    .weights_ready (weights_ready),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] words [0:159];

  logic [BAW-1:0]    wr_addr [$];
  logic [LINE_W-1:0] wr_data [$];
  int                wr_cyc  [$];
  int done_cnt = 0, done_cyc = 0, wait_cnt = 0, en_bad = 0;
  bit busy_at_done = 1'b0, rdy_at_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive recorder of BRAM writes, done pulses and stall cycles
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_we) begin
        wr_addr.push_back(bram_addr);
        wr_data.push_back(bram_wdata);
        wr_cyc.push_back(cyc);
      end
      if (bram_en !== bram_we) en_bad++;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
        rdy_at_done  = weights_ready;
      end
      if (busy && !s_if.s_ready) wait_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    int k;
    k = 0;
    n_assert++;
    assert (obs === exp) else begin
      for (int i = WPL - 1; i >= 0; i--)
        if (obs[i*AXW +: AXW] !== exp[i*AXW +: AXW]) k = i;
      n_fail++;
      $error("FAIL %s: word %0d observed 0x%0h expected 0x%0h", tag, k,
             obs[k*AXW +: AXW], exp[k*AXW +: AXW]);
    end
  endtask

  // Reference line: word i of a line sits at bits [32*i+31:32*i]
  function automatic logic [LINE_W-1:0] exp_line(input int first);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WPL; i++) l[i*AXW +: AXW] = words[first + i];
    return l;
  endfunction

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    wait_cnt = 0;
  endtask

  task automatic fill_words(input bit rnd);
    for (int i = 0; i < 160; i++) words[i] = rnd ? $urandom : 32'(i);
  endtask

  task automatic do_start(input int base, input int nl);
    @(negedge clk);
    start     = 1'b1;
    base_addr = BAW'(base);
    num_lines = (BAW+1)'(nl);
    @(negedge clk);
    start     = 1'b0;
    base_addr = BAW'($urandom);
    num_lines = (BAW+1)'($urandom);
    check("start_busy", 64'(busy), 64'(nl != 0));
    check("start_ready", 64'(s_if.s_ready), 64'(nl != 0));
  endtask

  task automatic feed(input int first, input int count, input bit gaps,
                      input int last_idx, input int stray_idx);
    int i, budget;
    bit v;
    i = 0;
    budget = 0;
    while (i < count && budget < 4000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_if.s_valid = v;
      s_if.s_data  = v ? words[first + i] : AXW'($urandom);
      s_if.s_last  = v && (first + i == last_idx);
      if (first + i == stray_idx) begin
        start     = 1'b1;
        base_addr = BAW'(7);
        num_lines = '0;
      end else begin
        start = 1'b0;
      end
      if (v && s_if.s_ready) i++;
      @(negedge clk);
      budget++;
    end
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    start        = 1'b0;
    check("feed_words_accepted", 64'(i), 64'(count));
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    check({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(n));
    for (int j = 0; j < n && j < wr_addr.size(); j++) begin
      check($sformatf("%s_addr%0d", tag, j), 64'(wr_addr[j]), 64'((base + j) % 4096));
      check_line($sformatf("%s_line%0d", tag, j), wr_data[j], exp_line(j * WPL));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(s_if.s_ready), 64'(0));
    check({tag, "_bram_en"}, 64'(bram_en), 64'(0));
    check({tag, "_bram_we"}, 64'(bram_we), 64'(0));
    check({tag, "_bram_addr"}, 64'(bram_addr), 64'(0));
    check({tag, "_bram_wdata_or"}, 64'(|bram_wdata), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_weights_ready"}, 64'(weights_ready), 64'(0));
    check({tag, "_error"}, 64'(error), 64'(0));
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    s_if.s_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-line continuous load, word n = n
    fill_words(1'b0);
    clear_mon();
    do_start(12'h010, 2);
    feed(0, 80, 1'b0, 79, -1);
    repeat (3) @(negedge clk);
    check_writes("cont", 12'h010, 2);
    check("cont_done_cnt", 64'(done_cnt), 64'(1));
    check("cont_stall_cycles", 64'(wait_cnt), 64'(2));
    if (wr_cyc.size() == 2) begin
      check("cont_line_period", 64'(wr_cyc[1] - wr_cyc[0]), 64'(WPL + 1));
      check("cont_done_latency", 64'(done_cyc - wr_cyc[1]), 64'(1));
    end
    check("cont_busy_at_done", 64'(busy_at_done), 64'(0));
    check("cont_ready_at_done", 64'(rdy_at_done), 64'(1));
    check("cont_weights_ready", 64'(weights_ready), 64'(1));
    check("cont_error", 64'(error), 64'(0));

    // Same load with random valid gaps
    clear_mon();
    do_start(12'h010, 2);
    feed(0, 80, 1'b1, 79, -1);
    repeat (3) @(negedge clk);
    check_writes("gaps", 12'h010, 2);
    check("gaps_done_cnt", 64'(done_cnt), 64'(1));
    check("gaps_stall_cycles", 64'(wait_cnt), 64'(2));
    check("gaps_weights_ready", 64'(weights_ready), 64'(1));

    // Zero lines: done the cycle after start, no write
    clear_mon();
    do_start(12'h123, 0);
    check("zero_done_t1", 64'(done), 64'(1));
    check("zero_ready_t1", 64'(weights_ready), 64'(1));
    repeat (3) @(negedge clk);
    check("zero_nwrites", 64'(wr_addr.size()), 64'(0));
    check("zero_done_cnt", 64'(done_cnt), 64'(1));
    check("zero_weights_ready", 64'(weights_ready), 64'(1));

    // Early s_last inside the second line
    fill_words(1'b1);
    clear_mon();
    do_start(12'h040, 2);
    feed(0, 46, 1'b1, 45, -1);
    check("early_error", 64'(error), 64'(1));
    check("early_busy", 64'(busy), 64'(0));
    check("early_s_ready", 64'(s_if.s_ready), 64'(0));
    repeat (3) @(negedge clk);
    check_writes("early", 12'h040, 1);
    check("early_done_cnt", 64'(done_cnt), 64'(0));
    check("early_weights_ready", 64'(weights_ready), 64'(0));
    check("early_error_sticky", 64'(error), 64'(1));
    do_start(12'h000, 0);
    check("early_error_cleared", 64'(error), 64'(0));
    repeat (2) @(negedge clk);

    // Address wrap
    fill_words(1'b1);
    clear_mon();
    do_start(12'hFFF, 2);
    feed(0, 80, 1'b1, 79, -1);
    repeat (3) @(negedge clk);
    check_writes("wrap", 12'hFFF, 2);
    check("wrap_weights_ready", 64'(weights_ready), 64'(1));

    // Stray start mid-FILL, then reset during the second line
    fill_words(1'b1);
    clear_mon();
    do_start(12'h100, 3);
    feed(0, 45, 1'b1, -1, 10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_writes("midrst", 12'h100, 1);
    check("midrst_done_cnt", 64'(done_cnt), 64'(0));
    check("midrst_weights_ready", 64'(weights_ready), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("en_follows_we", 64'(en_bad), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_weight_loader.md
# bram_weight_loader

Upstream fill stage for the weight BRAM. It accepts a 32-bit valid/ready word stream from the AXI side and packs `WORDS_PER_LINE` words into one `5*MAC_NUM`-bit BRAM line. It writes each completed line to consecutive BRAM addresses starting at a programmed base. It flags completion so the read-side BRAM controller can reset its address and begin streaming weights to the MAC array.

## Interface

Parameters:

- `MAC_NUM`, 256: MACs per line; the line width is `LINE_W = 5*MAC_NUM`.
- `BRAM_ADDRESS_WIDTH`, 12: BRAM address width.
- `AXI_DATA_WIDTH`, 32: input word width. `LINE_W` must be an integer multiple of it, giving `WORDS_PER_LINE = LINE_W/AXI_DATA_WIDTH` (40 at defaults).

Ports:

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle load request; sampled only in IDLE.
- `base_addr` in `BRAM_ADDRESS_WIDTH`: first BRAM line address; latched on accepted `start`.
- `num_lines` in `BRAM_ADDRESS_WIDTH+1`: number of lines to load; latched on accepted `start`.
- `s_data` in `AXI_DATA_WIDTH`: input word.
- `s_valid` in 1: `s_data` is valid.
- `s_last` in 1: marks the final word of the transfer.
- `s_ready` out 1: the block accepts a word this cycle.
- `bram_en` out 1: BRAM port enable.
- `bram_we` out 1: BRAM write enable.
- `bram_addr` out `BRAM_ADDRESS_WIDTH`: write address.
- `bram_wdata` out `LINE_W`: packed line.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse when a load completes.
- `weights_ready` out 1: level signal; the BRAM holds a complete load.
- `error` out 1: sticky; an early `s_last` was received.

## Operation

- States:
  - IDLE: waiting for `start`.
  - FILL: accepting words into the line buffer.
  - WRITE: issuing one BRAM write.
  - DONE: signalling completion.
- IDLE:
  - `s_ready`=0.
  - On `start`: latch `base_addr` into the address counter and `num_lines` into the line counter, clear the word counter, clear `error`, clear `weights_ready`.
  - If `num_lines`=0, go to DONE; otherwise go to FILL.
- FILL:
  - `s_ready`=1.
  - On handshake (`s_valid & s_ready`), word `i` of the line is written to line-buffer bits `[32*i+31:32*i]`; word 0 occupies the LSBs.
  - When word `WORDS_PER_LINE-1` is accepted, the word counter clears and the state goes to WRITE.
- WRITE:
  - `s_ready`=0; `bram_we`=1 and `bram_en`=1 for exactly one cycle, with `bram_addr` = the current address counter and `bram_wdata` = the line buffer.
  - Next cycle: the address counter increments by 1, wrapping modulo `2^BRAM_ADDRESS_WIDTH`, and the remaining-line count decrements.
  - If the remaining-line count was 1, go to DONE; otherwise return to FILL.
- DONE:
  - `done`=1 for one cycle and `weights_ready` is set; then return to IDLE.
- `s_last` handling:
  - `s_last` accepted on the final word of the final line is normal.
  - `s_last` accepted on any other word sets `error` and moves to IDLE. The partial line is not written; `done` and `weights_ready` stay low.
  - A missing `s_last` on the final word is not an error.
- `start` in any state other than IDLE is ignored. Latched parameters do not change during a load.
- `busy` = state is FILL or WRITE. `bram_en` = `bram_we` = state is WRITE.
- Reset:
  - All counters clear; the state goes to IDLE.
  - All outputs reset to 0: `s_ready`, `bram_en`, `bram_we`, `bram_addr`, `bram_wdata`, `busy`, `done`, `weights_ready`, `error`.
  - Reset mid-load abandons the transfer. Lines already written remain in the BRAM, but `weights_ready` stays 0.

## Timing

- `start` at cycle T in IDLE: `busy` and `s_ready` are high from T+1.
- The last word of a line is accepted at cycle k: `bram_we`=1 at k+1, `s_ready`=0 at k+1, FILL resumes at k+2.
- Peak throughput is one line per `WORDS_PER_LINE`+1 cycles.
- Final write at cycle m: `done`=1 and `weights_ready`=1 at m+1, `busy`=0 at m+1.
- `num_lines`=0 with `start` at T: `done`=1 at T+1, and no BRAM write occurs.
- `s_valid` gaps stall FILL without losing data; `s_data` is sampled only on handshake.
- `bram_addr` and `bram_wdata` are registered and hold stable through the `bram_we` cycle.

## Test plan

- **Two-line continuous load.** Stimulus: `base_addr`=0x010, `num_lines`=2, 80 words of value `n`, `s_valid` held high. Required: two writes, to 0x010 and 0x011, each with word0=0 and 40 respectively in the LSBs. `s_ready` drops for exactly one cycle after the 40th and 80th words. `done` pulses once, and `weights_ready`=1.
- **Backpressure and gaps.** Stimulus: same load, with `s_valid` toggling pseudo-randomly. Required: identical BRAM contents and no dropped or duplicated words.
- **Zero lines.** Stimulus: `num_lines`=0. Required: `done` at T+1, `bram_we` never asserts, and `weights_ready`=1.
- **Early `s_last`.** Stimulus: `num_lines`=2, `s_last` on word 45. Required: only address `base` is written. Then `error`=1, the state is IDLE, `done`=0, and `weights_ready`=0. The next `start` clears `error`.
- **Address wrap.** Stimulus: `base_addr`=0xFFF, `num_lines`=2. Required: writes land at 0xFFF, then 0x000.
- **Ignored start and mid-load reset.** Stimulus: `start` pulsed mid-FILL, then `rst_n` low during the second line. Required: the stray `start` has no effect. After reset, all outputs are 0 and the first line's write is not repeated.
